divider_recon_checker: RTL
==========================

// Module: divider_recon_checker
// PURPOSE
//  Inverse of the combinational array divider: takes one divider result (q, r) with its operands (n, d),
//  rebuilds n_hat = q*d + r with a W-cycle shift-add multiplier, and reports the signed error against n.
//  Keeps running saturating totals (samples, mismatches, sum |err|) for power/MSE characterisation of the
//  approximate divider variants. Sits between a divider instance and the characterisation bench/scoreboard.
// PARAMETERS
//  W      8   quotient/divisor/remainder width; numerator and n_hat are 2W bits
//  ACC_W  32  width of the statistics counters
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        synchronous, active-high reset
//  in_valid      in   1        operand/result tuple valid
//  in_ready      out  1        block can accept a tuple (high only in IDLE and not in reset)
//  n             in   2W       original numerator
//  d             in   W        divisor
//  q             in   W        quotient under test
//  r             in   W        remainder under test
//  acc_clr       in   1        synchronous clear of the statistics counters
//  out_valid     out  1        result valid; held until out_ready
//  out_ready     in   1        consumer accepts the result
//  n_hat         out  2W       q*d + r (never overflows: max (2^W-1)^2 + 2^W-1 < 2^2W)
//  err           out  2W+1     signed n_hat - n, two's complement
//  abs_err       out  2W       |err|
//  div_by_zero   out  1        d == 0 on the captured tuple
//  rem_invalid   out  1        d != 0 and r >= d on the captured tuple
//  sample_cnt    out  ACC_W    results completed since clear; saturates at all-ones
//  mismatch_cnt  out  ACC_W    results with err != 0; saturates
//  sum_abs_err   out  ACC_W    sum of abs_err; saturates at all-ones, no wrap
// BEHAVIOUR
//  - Reset: state IDLE; every output, datapath register and counter is 0; in_ready = 0 while rst is high.
//    Reset mid-operation aborts the tuple: no out_valid, no counter update.
//  - FSM IDLE -> MUL -> CALC -> DONE -> IDLE.
//  - IDLE: in_ready = 1. On in_valid & in_ready, capture n, d, q, r; P = zero-extended r; mcand = zero-extended d;
//    mplier = q; cnt = 0; go to MUL. Flags div_by_zero and rem_invalid are computed from the captured values.
//  - MUL: exactly W cycles; each cycle: if mplier[0], P += mcand (2W bits); mcand <<= 1; mplier >>= 1; cnt++.
//    Leave for CALC when cnt == W-1. q = 0 or d = 0 still takes W cycles (fixed latency).
//  - CALC: one cycle; n_hat = P; err = {1'b0,P} - {1'b0,n}; abs_err = magnitude; counters update;
//    out_valid set at the end of this cycle; go to DONE.
//  - Latency: out_valid rises W+1 clock edges after the accepting edge (9 for W=8).
//  - DONE: out_valid = 1, all result outputs stable; in_ready = 0. On out_ready, out_valid drops next edge,
//    state returns to IDLE. Throughput is one tuple per W+3 cycles minimum.
//  - Counters: sample_cnt +1, mismatch_cnt +1 if err != 0, sum_abs_err += abs_err; each saturates independently.
//  - acc_clr zeroes all three counters next edge; if asserted in the CALC cycle, clear wins and that sample is
//    not counted (the result is still delivered). acc_clr does not affect the FSM or result outputs.
//  - in_valid while not ready is ignored; inputs are sampled only on the accepting edge.
// TESTING
//  1. n=1000,d=7,q=142,r=6 -> n_hat=1000, err=0, abs_err=0, out_valid exactly 9 edges after accept, sample_cnt=1
//  2. n=1000,d=7,q=140,r=6 -> n_hat=986, err=-14 (17'h1FFF2), abs_err=14, mismatch_cnt=1, sum_abs_err=14
//  3. n=0,d=255,q=255,r=255 -> n_hat=65280, err=+65280, rem_invalid=1; then d=0,q=5,r=3,n=3 -> n_hat=3, div_by_zero=1
//  4. out_ready low 5 cycles in DONE -> outputs unchanged, in_ready=0, extra in_valid ignored; release -> IDLE, next accept
//  5. rst at 4th MUL cycle -> no out_valid, counters 0, in_ready=1 first cycle after rst falls; acc_clr in CALC -> counters 0
//  6. sum_abs_err preset near saturation (ACC_W=16, repeated abs_err=65280) -> sticks at 16'hFFFF, no wrap

Source files
------------

// File: rtl/divider_recon_checker_if.sv
// Handshake and result bundle between a divider tuple source and divider_recon_checker.
// The master drives tuples and out_ready; the slave (the checker) returns the reconstructed result.
interface divider_recon_checker_if #(
  parameter int W = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  n;
  logic [W-1:0]    d;
  logic [W-1:0]    q;
  logic [W-1:0]    r;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  n_hat;
  logic [2*W:0]    err;
  logic [2*W-1:0]  abs_err;
  logic            div_by_zero;
  logic            rem_invalid;

  modport master (
    output in_valid, n, d, q, r, out_ready,
    input  in_ready, out_valid, n_hat, err, abs_err, div_by_zero, rem_invalid
  );

  modport slave (
    input  in_valid, n, d, q, r, out_ready,
    output in_ready, out_valid, n_hat, err, abs_err, div_by_zero, rem_invalid
  );
endinterface

// File: rtl/divider_recon_checker.sv
// Rebuilds n_hat = q*d + r with a W-cycle shift-add multiplier, reports the signed error against n
// and keeps saturating sample / mismatch / |err| totals for approximate-divider characterisation.
module divider_recon_checker #(
  parameter int W     = 8,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  divider_recon_checker_if.slave bus,
  input  logic                 acc_clr,
  output logic [ACC_W-1:0]     sample_cnt,
  output logic [ACC_W-1:0]     mismatch_cnt,
  output logic [ACC_W-1:0]     sum_abs_err
);

  localparam int NW    = 2 * W;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam int SUM_W = ((ACC_W > NW) ? ACC_W : NW) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, MUL, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [NW-1:0]     n_reg;
  logic [NW-1:0]     p;
  logic [NW-1:0]     mcand;
  logic [W-1:0]      mplier;
  logic [CNT_W-1:0]  cnt;

  logic              out_valid_q;
  logic [NW-1:0]     n_hat_q;
  logic [NW:0]       err_q;
  logic [NW-1:0]     abs_err_q;
  logic              div_by_zero_q;
  logic              rem_invalid_q;

  logic              in_ready;
  logic              accept;
  logic              mul_last;
  logic [NW:0]       err_c;
  logic [NW:0]       err_neg;
  logic [NW-1:0]     abs_c;
  logic [SUM_W-1:0]  sum_wide;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_ready && bus.in_valid;
  assign mul_last = (cnt == CNT_W'(W - 1));

  // Product plus remainder can never exceed 2W bits, so a zero-extended subtract gives the exact signed error.
  assign err_c    = {1'b0, p} - {1'b0, n_reg};
  assign err_neg  = ~err_c + {{NW{1'b0}}, 1'b1};
  assign abs_c    = err_c[NW] ? err_neg[NW-1:0] : err_c[NW-1:0];
  assign sum_wide = SUM_W'(sum_abs_err) + SUM_W'(abs_c);

  always_comb begin
    // NOTE: state_next takes its default before the case so no path leaves it unassigned and infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (accept)        state_next = MUL;
      MUL:     if (mul_last)      state_next = CALC;
      CALC:                       state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: this synchronous reset clears every register; there are no memory arrays left unreset.
    if (rst) begin
      state         <= IDLE;
      n_reg         <= '0;
      p             <= '0;
      mcand         <= '0;
      mplier        <= '0;
      cnt           <= '0;
      out_valid_q   <= 1'b0;
      n_hat_q       <= '0;
      err_q         <= '0;
      abs_err_q     <= '0;
      div_by_zero_q <= 1'b0;
      rem_invalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            n_reg         <= bus.n;
            p             <= {{W{1'b0}}, bus.r};
            mcand         <= {{W{1'b0}}, bus.d};
            mplier        <= bus.q;
            cnt           <= '0;
            div_by_zero_q <= (bus.d == '0);
            rem_invalid_q <= (bus.d != '0) && (bus.r >= bus.d);
          end
        end
        MUL: begin
          // Fixed W iterations even for zero operands, so latency never depends on data.
          if (mplier[0]) p <= p + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        CALC: begin
          n_hat_q     <= p;
          err_q       <= err_c;
          abs_err_q   <= abs_c;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Statistics: a clear in the CALC cycle wins over that cycle's update.
  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      sum_abs_err  <= '0;
    end else if (state == CALC) begin
      if (sample_cnt != ACC_MAX) sample_cnt <= sample_cnt + ACC_W'(1);
      if ((err_c != '0) && (mismatch_cnt != ACC_MAX)) mismatch_cnt <= mismatch_cnt + ACC_W'(1);
      sum_abs_err <= (sum_wide > SUM_W'(ACC_MAX)) ? ACC_MAX : sum_wide[ACC_W-1:0];
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.n_hat       = n_hat_q;
  assign bus.err         = err_q;
  assign bus.abs_err     = abs_err_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.rem_invalid = rem_invalid_q;

endmodule
